sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbiter that shares one single-port synchronous SRAM between the CPU instruction-fetch port and data-access port. It sits between the pipeline's fetch/memory stages and a unified memory. It uses a req/addr_ok/data_ok handshake on each side and keeps one transaction in flight at a time. Data has priority over instruction fetch, with a starvation bound.

## Interface
Parameters:
- `MEM_LAT`, default 1: number of cycles from SRAM issue until `sram_rdata` is valid. Legal range is 1..4.
- `STARVE_LIMIT`, default 4: maximum number of consecutive data grants allowed while `inst_req` is pending. Legal range is 1..15.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `resetn` in 1: reset is synchronous and active-low.
- `inst_req` in 1: fetch request.
- `inst_addr` in 32: fetch address.
- `inst_addr_ok` out 1: fetch request granted this cycle.
- `inst_data_ok` out 1: fetch response valid, one-cycle pulse.
- `inst_rdata` out 32: fetch data, valid while `inst_data_ok` is high.
- `data_req` in 1: data request.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_wstrb` in 4: byte enables for writes.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data.
- `data_addr_ok` out 1: data request granted.
- `data_data_ok` out 1: data response pulse. Returned for both reads and writes.
- `data_rdata` out 32: read data, valid while `data_data_ok` is high.
- `sram_en` out 1: SRAM access strobe.
- `sram_we` out 4: byte write enables.
- `sram_addr` out 32: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **Grant window.** A grant may occur only in IDLE or RESP. The grant cycle is combinational in that cycle:
  - `xx_addr_ok`=1.
  - `sram_en`=1.
  - `sram_addr`/`sram_wdata` come from the winner's inputs.
  - `sram_we` = `data_wstrb` for a data write, otherwise 0.
  - The winner's id (inst/data) and whether it is a write are registered.
  - Next state is WAIT, with `lat_cnt`=MEM_LAT-1.
- **Outside the grant cycle:** `sram_en`=0, `sram_we`=0, and `sram_addr`/`sram_wdata` are 0.
- **WAIT state:**
  - If `lat_cnt`==0: capture `sram_rdata` into the response register (capture 0 for writes) and go to RESP.
  - Otherwise, decrement `lat_cnt`.
- **RESP state:**
  - Assert the owner's `xx_data_ok` for exactly one cycle and drive its `xx_rdata`. The non-owner's `rdata` stays 0.
  - A new grant in the same cycle goes to WAIT; otherwise go to IDLE.
- **Arbitration:**
  - Both requesting:
    - Data wins, unless `starve_cnt`==STARVE_LIMIT.
    - When `starve_cnt`==STARVE_LIMIT, inst wins.
  - Only one requesting: that requester wins.
- **`starve_cnt` (4 bits):**
  - Increments on a data grant while `inst_req`=1.
  - Clears on an inst grant, or on any cycle with `inst_req`=0.
  - Saturates at STARVE_LIMIT.
- **Requester rule.** Requester rule (not checked by the arbiter): hold `req` and its payload stable until `addr_ok`. The arbiter never latches a request without asserting `addr_ok`.
- **Reset.** While `resetn`=0:
  - State is IDLE; `lat_cnt`, `starve_cnt` and the response register are 0.
  - All outputs are 0.
  - Any in-flight transaction is dropped and produces no `data_ok`.

## Timing
- A grant in cycle T leads to:
  - WAIT during cycles T+1..T+MEM_LAT.
  - Capture at the end of T+MEM_LAT.
  - `data_ok` in T+MEM_LAT+1.
- Throughput is one transaction per MEM_LAT+1 cycles; back-to-back is achieved by granting during RESP.
- `addr_ok` and the `sram_*` outputs are combinational from `req` and state. `data_ok` and `rdata` are registered.
- No grant occurs during WAIT, even if a request is pending.
- With `MEM_LAT`=1, a response arrives 2 cycles after the grant.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles with both reqs high. All outputs read 0 and `busy`=0. The first grant (data) occurs in the cycle `resetn` goes high.
- **Single fetch, `MEM_LAT`=1:** `inst_req` with `inst_addr`=0x1c000000 at cycle T; memory returns 0x02800421.
  - `inst_addr_ok`=`sram_en`=1 and `sram_addr`=0x1c000000 at T.
  - `inst_data_ok`=1 with `inst_rdata`=0x02800421 at T+2.
- **Simultaneous requests, `STARVE_LIMIT`=4:** hold both reqs high continuously.
  - Grant sequence is D,D,D,D,I,D,D,D,D,I…
  - Grants are spaced MEM_LAT+1 cycles apart.
- **Byte write:** `data_wr`=1, `data_wstrb`=0b0100, addr 0x1000, wdata 0x00AB0000.
  - `sram_we`=0b0100 in the grant cycle only.
  - `data_data_ok` pulses at T+MEM_LAT+1 with `data_rdata`=0.
- **Reset mid-WAIT, `MEM_LAT`=3:** grant at T, then `resetn`=0 at T+2.
  - No `data_ok` is ever produced for that access.
  - State is IDLE after reset.
- **Back-to-back, `MEM_LAT`=2:** `data_req` held high with addresses 0x0, 0x4.
  - The second `data_addr_ok` occurs in the same cycle as the first `data_data_ok`, at T+3.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port synchronous SRAM between fetch and data ports
//
// Ports:
//   clk, resetn                   clock, synchronous active-low reset
//   inst_req/inst_addr            fetch request and address
//   inst_addr_ok                  fetch granted this cycle (combinational)
//   inst_data_ok/inst_rdata       fetch response pulse and data (registered)
//   data_req/data_wr/data_wstrb   data request, write flag, byte enables
//   data_addr/data_wdata          data address and write data
//   data_addr_ok                  data granted this cycle (combinational)
//   data_data_ok/data_rdata       data response pulse and read data (registered)
//   sram_en/sram_we/sram_addr     SRAM strobe, byte write enables, address
//   sram_wdata/sram_rdata         SRAM write and read data
//   busy                          FSM is not idle

module sram_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_data_q, owner_data_d;
  logic        wr_q, wr_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic grant_window;
  logic inst_wins;
  logic grant_inst;
  logic grant_data;
  logic grant_any;

  // Grants are only possible in IDLE or RESP; RESP grants give back-to-back throughput.
  assign grant_window = resetn && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  // Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
  assign inst_wins    = inst_req && (!data_req || (starve_cnt_q == STARVE_MAX));
  assign grant_inst   = grant_window && inst_wins;
  assign grant_data   = grant_window && data_req && !inst_wins;
  assign grant_any    = grant_inst || grant_data;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign sram_en      = grant_any;
  assign sram_we      = (grant_data && data_wr) ? data_wstrb : 4'b0000;
  assign sram_addr    = grant_data ? data_addr : (grant_inst ? inst_addr : 32'h0);
  assign sram_wdata   = grant_data ? data_wdata : 32'h0;

  // Registered responses are masked while reset is asserted so every output reads 0.
  assign inst_data_ok = resetn && inst_ok_q;
  assign data_data_ok = resetn && data_ok_q;
  assign inst_rdata   = resetn ? inst_rdata_q : 32'h0;
  assign data_rdata   = resetn ? data_rdata_q : 32'h0;
  assign busy         = resetn && (state_q != ST_IDLE);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || grant_inst) begin
      starve_cnt_d = 4'd0;
    end else if (grant_data && (starve_cnt_q < STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    owner_data_d = owner_data_q;
    wr_d         = wr_q;
    // Response registers default low so data_ok is a single-cycle pulse.
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = 32'h0;
    data_rdata_d = 32'h0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant_any) begin
          state_d      = ST_WAIT;
          lat_cnt_d    = LAT_INIT;
          owner_data_d = grant_data;
          wr_d         = grant_data && data_wr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          state_d = ST_RESP;
          if (owner_data_q) begin
            data_ok_d    = 1'b1;
            data_rdata_d = wr_q ? 32'h0 : sram_rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = sram_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      owner_data_q <= 1'b0;
      wr_q         <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_data_q <= owner_data_d;
      wr_q         <= wr_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench for sram_arbiter at MEM_LAT 1, 2 and 3

module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] sram_rdata;

  // Index k drives the instance with MEM_LAT = k+1; all share the same inputs.
  logic        inst_addr_ok [3];
  logic        inst_data_ok [3];
  logic [31:0] inst_rdata   [3];
  logic        data_addr_ok [3];
  logic        data_data_ok [3];
  logic [31:0] data_rdata   [3];
  logic        sram_en      [3];
  logic [3:0]  sram_we      [3];
  logic [31:0] sram_addr    [3];
  logic [31:0] sram_wdata   [3];
  logic        busy         [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_arbiter #(.MEM_LAT(g + 1), .STARVE_LIMIT(4)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .sram_en      (sram_en[g]),
      .sram_we      (sram_we[g]),
      .sram_addr    (sram_addr[g]),
      .sram_wdata   (sram_wdata[g]),
      .sram_rdata   (sram_rdata),
      .busy         (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic quiesce(input int n);
    inst_req   = 1'b0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    repeat (n) adv();
  endtask

  initial begin
    resetn     = 1'b0;
    inst_req   = 1'b1;
    inst_addr  = 32'h0000_0200;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'h0;
    sram_rdata = 32'h0;

    // Reset held three cycles with both requests asserted.
    repeat (3) adv();
    smp();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_inst_addr_ok[%0d]", k), 32'(inst_addr_ok[k]), 32'd0);
      chk($sformatf("rst_data_addr_ok[%0d]", k), 32'(data_addr_ok[k]), 32'd0);
      chk($sformatf("rst_sram_en[%0d]", k),      32'(sram_en[k]),      32'd0);
      chk($sformatf("rst_sram_addr[%0d]", k),    sram_addr[k],         32'd0);
      chk($sformatf("rst_busy[%0d]", k),         32'(busy[k]),         32'd0);
      chk($sformatf("rst_data_ok[%0d]", k),      32'(data_data_ok[k]), 32'd0);
    end

    // Release reset with both requests high: grants on MEM_LAT=1 go D,D,D,D,I repeating.
    adv();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int  gi;
      logic exp_i;
      logic prev_i;
      smp();
      gi     = i / 2;
      exp_i  = ((gi % 5) == 4);
      prev_i = (((gi - 1) % 5) == 4);
      if ((i % 2) == 0) begin
        chk($sformatf("arb_inst_ok c%0d", i), 32'(inst_addr_ok[0]), 32'(exp_i));
        chk($sformatf("arb_data_ok c%0d", i), 32'(data_addr_ok[0]), 32'(!exp_i));
        chk($sformatf("arb_sram_addr c%0d", i), sram_addr[0],
            exp_i ? 32'h0000_0200 : 32'h0000_0100);
        if (i > 0) begin
          chk($sformatf("arb_resp_d c%0d", i), 32'(data_data_ok[0]), 32'(!prev_i));
          chk($sformatf("arb_resp_i c%0d", i), 32'(inst_data_ok[0]), 32'(prev_i));
        end
      end else begin
        chk($sformatf("arb_wait_inst c%0d", i), 32'(inst_addr_ok[0]), 32'd0);
        chk($sformatf("arb_wait_data c%0d", i), 32'(data_addr_ok[0]), 32'd0);
        chk($sformatf("arb_wait_en c%0d", i),   32'(sram_en[0]),      32'd0);
        chk($sformatf("arb_wait_busy c%0d", i), 32'(busy[0]),         32'd1);
      end
      adv();
    end
    quiesce(10);

    // Single fetch on MEM_LAT=1.
    inst_req   = 1'b1;
    inst_addr  = 32'h1c00_0000;
    sram_rdata = 32'h0280_0421;
    smp();
    chk("fetch_addr_ok", 32'(inst_addr_ok[0]), 32'd1);
    chk("fetch_sram_en", 32'(sram_en[0]),      32'd1);
    chk("fetch_addr",    sram_addr[0],         32'h1c00_0000);
    chk("fetch_we",      32'(sram_we[0]),      32'd0);
    adv();
    inst_req = 1'b0;
    smp();
    chk("fetch_t1_ok",   32'(inst_data_ok[0]), 32'd0);
    chk("fetch_t1_en",   32'(sram_en[0]),      32'd0);
    chk("fetch_t1_busy", 32'(busy[0]),         32'd1);
    adv();
    smp();
    chk("fetch_t2_ok",    32'(inst_data_ok[0]), 32'd1);
    chk("fetch_t2_rdata", inst_rdata[0],        32'h0280_0421);
    chk("fetch_t2_drd",   data_rdata[0],        32'd0);
    chk("fetch_t2_dok",   32'(data_data_ok[0]), 32'd0);
    adv();
    smp();
    chk("fetch_t3_ok",   32'(inst_data_ok[0]), 32'd0);
    chk("fetch_t3_busy", 32'(busy[0]),         32'd0);
    quiesce(8);

    // Byte write: response at T+2 on MEM_LAT=1 and T+3 on MEM_LAT=2, data always 0.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'b0100;
    data_addr  = 32'h0000_1000;
    data_wdata = 32'h00AB_0000;
    sram_rdata = 32'hDEAD_BEEF;
    smp();
    chk("wr_addr_ok", 32'(data_addr_ok[1]), 32'd1);
    chk("wr_we",      32'(sram_we[1]),      32'b0100);
    chk("wr_addr",    sram_addr[1],         32'h0000_1000);
    chk("wr_wdata",   sram_wdata[1],        32'h00AB_0000);
    adv();
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    smp();
    chk("wr_t1_we",    32'(sram_we[1]),    32'd0);
    chk("wr_t1_wdata", sram_wdata[1],      32'd0);
    adv();
    smp();
    chk("wr_t2_ok_l2",    32'(data_data_ok[1]), 32'd0);
    chk("wr_t2_ok_l1",    32'(data_data_ok[0]), 32'd1);
    chk("wr_t2_rdata_l1", data_rdata[0],        32'd0);
    adv();
    smp();
    chk("wr_t3_ok",    32'(data_data_ok[1]), 32'd1);
    chk("wr_t3_rdata", data_rdata[1],        32'd0);
    adv();
    smp();
    chk("wr_t4_ok", 32'(data_data_ok[1]), 32'd0);
    quiesce(8);

    // Reset during WAIT on MEM_LAT=3: the access must never complete.
    data_req   = 1'b1;
    data_addr  = 32'h0000_0040;
    sram_rdata = 32'h1234_5678;
    smp();
    chk("rw_addr_ok", 32'(data_addr_ok[2]), 32'd1);
    adv();
    data_req = 1'b0;
    smp();
    chk("rw_t1_busy", 32'(busy[2]), 32'd1);
    adv();
    resetn = 1'b0;
    smp();
    chk("rw_t2_busy", 32'(busy[2]), 32'd0);
    adv();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk($sformatf("rw_no_ok c%0d", i),   32'(data_data_ok[2]), 32'd0);
      chk($sformatf("rw_idle c%0d", i),    32'(busy[2]),         32'd0);
      adv();
    end
    quiesce(4);

    // Back-to-back reads on MEM_LAT=2: second grant coincides with first response.
    data_req   = 1'b1;
    data_addr  = 32'h0000_0000;
    sram_rdata = 32'hA0A0_A0A0;
    smp();
    chk("b2b_t0_ok",   32'(data_addr_ok[1]), 32'd1);
    chk("b2b_t0_addr", sram_addr[1],         32'h0);
    adv();
    data_addr = 32'h0000_0004;
    smp();
    chk("b2b_t1_ok", 32'(data_addr_ok[1]), 32'd0);
    adv();
    smp();
    chk("b2b_t2_ok", 32'(data_addr_ok[1]), 32'd0);
    adv();
    smp();
    chk("b2b_t3_addr_ok", 32'(data_addr_ok[1]), 32'd1);
    chk("b2b_t3_data_ok", 32'(data_data_ok[1]), 32'd1);
    chk("b2b_t3_rdata",   data_rdata[1],        32'hA0A0_A0A0);
    chk("b2b_t3_addr",    sram_addr[1],         32'h0000_0004);
    adv();
    data_req   = 1'b0;
    sram_rdata = 32'h5B5B_5B5B;
    smp();
    chk("b2b_t4_busy", 32'(busy[1]),         32'd1);
    chk("b2b_t4_ok",   32'(data_data_ok[1]), 32'd0);
    adv();
    adv();
    smp();
    chk("b2b_t6_ok",    32'(data_data_ok[1]), 32'd1);
    chk("b2b_t6_rdata", data_rdata[1],        32'h5B5B_5B5B);
    quiesce(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
